matrix_frame_buffer: RTL and testbench

- Double-buffered 8x8 frame store sitting directly upstream of the MAX7219 matrix controller.
- Game logic writes rows into the back bank. The controller reads the front bank through its row-address/row-data pair.
- Bank swap and vertical road-scroll updates are deferred to a frame boundary, so the display never shows a torn frame.
- A back-bank clear sequencer wipes the back bank between frames.

---
 rtl/matrix_frame_buffer.sv | 170 +++++++++++++++++
 tb/tb_matrix_frame_buffer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/matrix_frame_buffer.sv
// Double-buffered 8x8 frame store feeding the MAX7219 matrix controller; swap and scroll apply at frame boundaries.
// Optional build macro MATRIX_FB_MIRROR_EN bit-reverses each displayed row for mirrored matrix mounting.
module matrix_frame_buffer #(
  parameter int ROW_W  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_row,
  input  logic [ROW_W-1:0]  wr_data,
  input  logic              clear_req,
  input  logic              swap_req,
  input  logic              scroll_step,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [ROW_W-1:0]  disp_data,
  output logic              busy,
  output logic              swap_ack,
  output logic              frame_tick,
  output logic [ADDR_W-1:0] scroll_offset
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, CLEAR, SWAP_WAIT} state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] cnt_reg, cnt_next;
  logic              swap_pend_reg, swap_pend_next;
  logic              clear_row_en, swap_fire, wr_ok;

  logic              front_sel_reg;
  logic [ADDR_W-1:0] prev_addr_reg;
  logic [ADDR_W-1:0] scroll_offset_reg;
  logic [ADDR_W-1:0] pend_reg, pend_next;
  logic              frame_tick_reg, swap_ack_reg;
  logic [ROW_W-1:0]  disp_data_reg;

  logic [ROW_W-1:0]  bank0_q [DEPTH];
  logic [ROW_W-1:0]  bank1_q [DEPTH];
  logic [ADDR_W-1:0] rd_idx;
  logic [ROW_W-1:0]  front_row, row_out;

  // ---------------- control FSM ----------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      swap_pend_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      swap_pend_reg <= swap_pend_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    swap_pend_next = swap_pend_reg;
    clear_row_en   = 1'b0;
    swap_fire      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (clear_req) begin
          state_next     = CLEAR;
          cnt_next       = '0;
          swap_pend_next = swap_req;
        end else if (swap_req) begin
          state_next = SWAP_WAIT;
        end
      end
      CLEAR: begin
        clear_row_en = 1'b1;
        cnt_next     = cnt_reg + ADDR_W'(1);
        if (swap_req) swap_pend_next = 1'b1;
        // A swap request arriving on the final clear row still counts.
        if (cnt_reg == LAST_ROW) begin
          state_next     = (swap_pend_reg || swap_req) ? SWAP_WAIT : IDLE;
          swap_pend_next = 1'b0;
        end
      end
      SWAP_WAIT: begin
        if (frame_tick_reg) begin
          swap_fire  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign wr_ok = wr_en && (state_reg != CLEAR);

  // ---------------- bank storage ----------------
  // Held in registers rather than block RAM so reset can zero every row at once.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_row
    logic [ROW_W-1:0] row0_reg, row1_reg;

    always_ff @(posedge clk) begin
      if (!reset) begin
        row0_reg <= '0;
        row1_reg <= '0;
      end else if (clear_row_en && (cnt_reg == ADDR_W'(gi))) begin
        if (front_sel_reg) row0_reg <= '0;
        else               row1_reg <= '0;
      end else if (wr_ok && (wr_row == ADDR_W'(gi))) begin
        if (front_sel_reg) row0_reg <= wr_data;
        else               row1_reg <= wr_data;
      end
    end

    assign bank0_q[gi] = row0_reg;
    assign bank1_q[gi] = row1_reg;
  end

  // ---------------- frame boundary, swap and scroll ----------------
  always_comb begin
    pend_next = pend_reg;
    if (scroll_step && (pend_reg != LAST_ROW)) pend_next = pend_reg + ADDR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      prev_addr_reg     <= '0;
      frame_tick_reg    <= 1'b0;
      swap_ack_reg      <= 1'b0;
      front_sel_reg     <= 1'b0;
      scroll_offset_reg <= '0;
      pend_reg          <= '0;
    end else begin
      prev_addr_reg  <= disp_addr;
      frame_tick_reg <= (prev_addr_reg == LAST_ROW) && (disp_addr == '0);
      swap_ack_reg   <= swap_fire;
      if (swap_fire) front_sel_reg <= ~front_sel_reg;
      // A step coinciding with the tick is carried into the next frame.
      if (frame_tick_reg) begin
        scroll_offset_reg <= scroll_offset_reg + pend_reg;
        pend_reg          <= scroll_step ? ADDR_W'(1) : '0;
      end else begin
        pend_reg <= pend_next;
      end
    end
  end

  // ---------------- read path ----------------
  assign rd_idx    = disp_addr + scroll_offset_reg;
  assign front_row = front_sel_reg ? bank1_q[rd_idx] : bank0_q[rd_idx];

`ifdef MATRIX_FB_MIRROR_EN
  for (genvar gi = 0; gi < ROW_W; gi++) begin : g_mirror
    assign row_out[gi] = front_row[ROW_W-1-gi];
  end
`else
  assign row_out = front_row;
`endif

  always_ff @(posedge clk) begin
    if (!reset) disp_data_reg <= '0;
    else        disp_data_reg <= row_out;
  end

  assign disp_data     = disp_data_reg;
  assign busy          = (state_reg != IDLE);
  assign swap_ack      = swap_ack_reg;
  assign frame_tick    = frame_tick_reg;
  assign scroll_offset = scroll_offset_reg;

endmodule

// File: tb/tb_matrix_frame_buffer.sv
// Scoreboard bench for matrix_frame_buffer: stimulus queues expected rows and swap acks, monitors compare.
module tb_matrix_frame_buffer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       wr_en = 1'b0;
  logic [2:0] wr_row = '0;
  logic [7:0] wr_data = '0;
  logic       clear_req = 1'b0;
  logic       swap_req = 1'b0;
  logic       scroll_step = 1'b0;
  logic [2:0] disp_addr = 3'd3;
  logic [7:0] disp_data;
  logic       busy, swap_ack, frame_tick;
  logic [2:0] scroll_offset;

  int total = 0;
  int bad   = 0;

  logic [7:0] rd_q [$];
  bit         ack_q [$];
  bit         rd_issue = 1'b0;
  bit         rd_pend  = 1'b0;

  matrix_frame_buffer #(.ROW_W(8), .ADDR_W(3)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_row(wr_row), .wr_data(wr_data),
    .clear_req(clear_req), .swap_req(swap_req), .scroll_step(scroll_step),
    .disp_addr(disp_addr), .disp_data(disp_data), .busy(busy), .swap_ack(swap_ack),
    .frame_tick(frame_tick), .scroll_offset(scroll_offset)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [7:0] dexp(input logic [7:0] v);
    logic [7:0] r;
`ifdef MATRIX_FB_MIRROR_EN
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
`else
    r = v;
`endif
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // Monitors: read data one cycle after issue, and every swap_ack pulse.
  always @(posedge clk) rd_pend <= rd_issue;

  always @(negedge clk) begin
    if (rd_pend) begin
      if (rd_q.size() == 0) begin
        chk("disp_data_unexpected", 1, 0);
      end else begin
        logic [7:0] e;
        e = rd_q.pop_front();
        chk("disp_data", disp_data, e);
      end
    end
  end

  always @(negedge clk) begin
    if (swap_ack) begin
      chk("swap_ack_expected", (ack_q.size() != 0), 1);
      if (ack_q.size() != 0) void'(ack_q.pop_front());
    end
  end

  // Stimulus tasks are entered and left on a falling edge.
  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_row = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, input logic [7:0] e);
    disp_addr = a; rd_issue = 1'b1; rd_q.push_back(e);
    @(negedge clk);
    rd_issue = 1'b0;
  endtask

  task automatic swap_pulse();
    swap_req = 1'b1;
    @(negedge clk);
    swap_req = 1'b0;
  endtask

  task automatic steps(input int n);
    scroll_step = 1'b1;
    repeat (n) @(negedge clk);
    scroll_step = 1'b0;
  endtask

  task automatic boundary(input bit expect_ack, input bit step_on_tick);
    disp_addr = 3'd7;
    @(negedge clk);
    disp_addr = 3'd0;
    @(negedge clk);
    chk("frame_tick_high", frame_tick, 1);
    if (expect_ack) ack_q.push_back(1'b1);
    scroll_step = step_on_tick;
    @(negedge clk);
    scroll_step = 1'b0;
    chk("frame_tick_low", frame_tick, 0);
  endtask

  initial begin
    int busy_cnt;
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // Reset state
    chk("rst_busy", busy, 0);
    chk("rst_scroll", scroll_offset, 0);
    chk("rst_tick", frame_tick, 0);
    chk("rst_ack", swap_ack, 0);
    chk("rst_data", disp_data, 0);
    rd(3'd3, dexp(8'h00));

    // Write back row 2, swap at frame boundary
    wr(3'd2, 8'hA5);
    rd(3'd2, dexp(8'h00));
    swap_pulse();
    chk("swap_wait_busy", busy, 1);
    rd(3'd2, dexp(8'h00));
    boundary(1'b1, 1'b0);
    chk("after_swap_busy", busy, 0);
    rd(3'd2, dexp(8'hA5));

    // Scroll: row 1 = 3C in front, offset 3
    wr(3'd1, 8'h3C);
    swap_pulse();
    boundary(1'b1, 1'b0);
    steps(3);
    chk("scroll_before_tick", scroll_offset, 0);
    boundary(1'b0, 1'b0);
    chk("scroll_3", scroll_offset, 3);
    rd(3'd6, dexp(8'h3C));
    rd(3'd5, dexp(8'h00));
    boundary(1'b0, 1'b0);
    chk("scroll_pend_zero", scroll_offset, 3);
    steps(9);
    boundary(1'b0, 1'b0);
    chk("scroll_saturate_wrap", scroll_offset, 2);
    boundary(1'b0, 1'b1);
    chk("scroll_step_on_tick", scroll_offset, 2);
    boundary(1'b0, 1'b0);
    chk("scroll_deferred", scroll_offset, 3);

    // Clear alone takes exactly 8 busy cycles
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    busy_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (busy) busy_cnt++;
      @(negedge clk);
    end
    chk("clear_cycles", busy_cnt, 8);

    // Fill back with FF, clear+swap together, writes ignored while clearing
    for (int i = 0; i < 8; i++) wr(3'(i), 8'hFF);
    clear_req = 1'b1; swap_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0; swap_req = 1'b0;
    wr_en = 1'b1; wr_row = 3'd0; wr_data = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      chk("clear_busy", busy, 1);
      @(negedge clk);
    end
    wr_en = 1'b0;
    chk("clear_then_swap_wait", busy, 1);
    boundary(1'b1, 1'b0);
    for (int i = 0; i < 8; i++) rd(3'(i), dexp(8'h00));

    // Reset while a swap is pending
    wr(3'd4, 8'h77);
    swap_pulse();
    chk("pending_busy", busy, 1);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("midswap_rst_busy", busy, 0);
    chk("midswap_rst_scroll", scroll_offset, 0);
    chk("midswap_rst_data", disp_data, 0);
    boundary(1'b0, 1'b0);
    chk("midswap_rst_idle", busy, 0);
    rd(3'd4, dexp(8'h00));
    rd(3'd1, dexp(8'h00));

    // Single-bit row exposes the mirror setting
    wr(3'd0, 8'h01);
    swap_pulse();
    boundary(1'b1, 1'b0);
    rd(3'd0, dexp(8'h01));
    rd(3'd3, dexp(8'h00));

    repeat (3) @(negedge clk);
    chk("ack_q_drained", ack_q.size(), 0);
    chk("rd_q_drained", rd_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
